// File: rtl/dbg_mem_arb_pkg.sv
// Shared types for the debug/pipeline memory-port arbiter: FSM states,
// transaction owner encoding and default bus widths.
package dbg_mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_DBG = 1'b0,
    OWN_PL  = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector. The pipeline input can be masked off
// (core halted); on a tie the requester that did not win last time wins.
module rr_arb2
  import dbg_mem_arb_pkg::*;
(
  input  logic   i_req_dbg,
  input  logic   i_req_pl,
  input  logic   i_mask_pl,
  input  owner_e i_last_owner,
  output owner_e o_winner,
  output logic   o_valid
);

  logic w_pl_elig;

  assign w_pl_elig = i_req_pl & ~i_mask_pl;
  assign o_valid   = i_req_dbg | w_pl_elig;

  always_comb begin
    o_winner = OWN_DBG;
    if (w_pl_elig && (!i_req_dbg || (i_last_owner == OWN_DBG))) begin
      o_winner = OWN_PL;
    end
  end

endmodule

// File: rtl/dbg_mem_arbiter.sv
// Serialises debug abstract accesses and pipeline loads/stores onto the single
// hart memory port, one transaction in flight, with a per-access timeout.
module dbg_mem_arbiter
  import dbg_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              halt_active_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rsp_valid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  input  logic              pl_req_i,
  input  logic              pl_we_i,
  input  logic [ADDR_W-1:0] pl_addr_i,
  input  logic [DATA_W-1:0] pl_wdata_i,
  output logic              pl_gnt_o,
  output logic              pl_rsp_valid_o,
  output logic [DATA_W-1:0] pl_rdata_o,
  output logic              pl_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e            r_state;
  owner_e            r_owner;
  owner_e            r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dbg_rsp_valid;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_dbg_err;
  logic              r_pl_rsp_valid;
  logic [DATA_W-1:0] r_pl_rdata;
  logic              r_pl_err;

  owner_e            w_winner;
  logic              w_valid;
  logic              w_grant;
  logic              w_done;
  logic              w_timeout;
  logic              w_finish;
  logic [DATA_W-1:0] w_rsp_data;

  rr_arb2 u_rr_arb2 (
    .i_req_dbg    (dbg_req_i),
    .i_req_pl     (pl_req_i),
    .i_mask_pl    (halt_active_i),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  assign w_grant   = (r_state == IDLE) && w_valid;
  assign dbg_gnt_o = w_grant && (w_winner == OWN_DBG);
  assign pl_gnt_o  = w_grant && (w_winner == OWN_PL);

  // A response in REQ only counts when the grant arrives alongside it.
  assign w_done = ((r_state == RSP) && mem_rsp_valid_i) ||
                  ((r_state == REQ) && mem_gnt_i && mem_rsp_valid_i);
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_state != IDLE) && !w_done && (r_cnt == TO_LAST);
  assign w_finish   = w_done || w_timeout;
  assign w_rsp_data = (w_timeout || r_we) ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= IDLE;
      r_owner         <= OWN_DBG;
      r_last_owner    <= OWN_PL;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_cnt           <= '0;
      r_dbg_rsp_valid <= 1'b0;
      r_dbg_rdata     <= '0;
      r_dbg_err       <= 1'b0;
      r_pl_rsp_valid  <= 1'b0;
      r_pl_rdata      <= '0;
      r_pl_err        <= 1'b0;
    end else begin
      r_dbg_rsp_valid <= w_finish && (r_owner == OWN_DBG);
      r_pl_rsp_valid  <= w_finish && (r_owner == OWN_PL);
      if (w_finish && (r_owner == OWN_DBG)) begin
        r_dbg_rdata <= w_rsp_data;
        r_dbg_err   <= w_timeout;
      end
      if (w_finish && (r_owner == OWN_PL)) begin
        r_pl_rdata <= w_rsp_data;
        r_pl_err   <= w_timeout;
      end
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state      <= REQ;
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_we         <= (w_winner == OWN_DBG) ? dbg_we_i    : pl_we_i;
            r_addr       <= (w_winner == OWN_DBG) ? dbg_addr_i  : pl_addr_i;
            r_wdata      <= (w_winner == OWN_DBG) ? dbg_wdata_i : pl_wdata_i;
            r_cnt        <= '0;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_finish) begin
            r_state <= IDLE;
          end else if (mem_gnt_i) begin
            r_state <= RSP;
          end
        end
        RSP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_finish) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o       = (r_state == REQ);
  assign mem_we_o        = r_we;
  assign mem_addr_o      = r_addr;
  assign mem_wdata_o     = r_wdata;
  assign busy_o          = (r_state != IDLE);
  assign dbg_rsp_valid_o = r_dbg_rsp_valid;
  assign dbg_rdata_o     = r_dbg_rdata;
  assign dbg_err_o       = r_dbg_err;
  assign pl_rsp_valid_o  = r_pl_rsp_valid;
  assign pl_rdata_o      = r_pl_rdata;
  assign pl_err_o        = r_pl_err;

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Scoreboard bench for dbg_mem_arbiter: grants push expected responses and
// expected port requests; monitor and memory responder pop and compare.
`timescale 1ns/1ps
module tb_dbg_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          halt_active_i = 1'b0;
  logic          dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [DW-1:0] dbg_wdata_i = '0;
  logic          pl_req_i = 1'b0, pl_we_i = 1'b0;
  logic [AW-1:0] pl_addr_i = '0;
  logic [DW-1:0] pl_wdata_i = '0;
  logic          mem_gnt_i = 1'b0, mem_rsp_valid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          dbg_gnt_o, dbg_rsp_valid_o, dbg_err_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          pl_gnt_o, pl_rsp_valid_o, pl_err_o;
  logic [DW-1:0] pl_rdata_o;
  logic          mem_req_o, mem_we_o, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;

  dbg_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .halt_active_i(halt_active_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rsp_valid_o(dbg_rsp_valid_o), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .pl_req_i(pl_req_i), .pl_we_i(pl_we_i), .pl_addr_i(pl_addr_i), .pl_wdata_i(pl_wdata_i),
    .pl_gnt_o(pl_gnt_o), .pl_rsp_valid_o(pl_rsp_valid_o), .pl_rdata_o(pl_rdata_o), .pl_err_o(pl_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic owner; logic [DW-1:0] rdata; logic err; } rsp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mreq_t;

  rsp_t  exp_q[$];
  mreq_t mreq_q[$];
  int    gnt_log[$];
  rsp_t  e_m;
  mreq_t m_r;
  int    checks = 0;
  int    errors = 0;
  // 0: grant, respond next cycle; 1: grant+respond together; 2: never grant; 3: grant, never respond
  int    mem_mode = 0;
  logic  stale = 1'b0;
  logic  rsp_pend = 1'b0;
  logic [DW-1:0] pend_data = '0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: responses are popped first, then any new grant is recorded.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (dbg_rsp_valid_o || pl_rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(dbg_rsp_valid_o | pl_rsp_valid_o), 32'd0);
        end else begin
          e_m = exp_q.pop_front();
          chk("rsp_owner", {31'd0, pl_rsp_valid_o}, {31'd0, e_m.owner});
          chk("rsp_rdata", e_m.owner ? pl_rdata_o : dbg_rdata_o, e_m.rdata);
          chk("rsp_err", {31'd0, e_m.owner ? pl_err_o : dbg_err_o}, {31'd0, e_m.err});
        end
      end
      if (dbg_gnt_o || pl_gnt_o) begin
        chk("one_gnt", 32'(dbg_gnt_o & pl_gnt_o), 32'd0);
        if (dbg_gnt_o) begin
          gnt_log.push_back(0);
          exp_q.push_back('{1'b0, (dbg_we_i || mem_mode == 2) ? 32'd0 : mem_data(dbg_addr_i), mem_mode == 2});
          mreq_q.push_back('{dbg_we_i, dbg_addr_i, dbg_wdata_i});
        end else begin
          gnt_log.push_back(1);
          exp_q.push_back('{1'b1, (pl_we_i || mem_mode == 2) ? 32'd0 : mem_data(pl_addr_i), mem_mode == 2});
          mreq_q.push_back('{pl_we_i, pl_addr_i, pl_wdata_i});
        end
      end
    end
  end

  // Memory port responder.
  always @(negedge clk_i) begin
    mem_gnt_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    if (reset_i) begin
      rsp_pend = 1'b0;
    end else if (stale) begin
      mem_gnt_i = 1'b1;
      mem_rsp_valid_i = 1'b1;
      mem_rdata_i = 32'hBAD0BAD0;
    end else if (rsp_pend) begin
      chk("req_low_in_rsp", 32'(mem_req_o), 32'd0);
      mem_rsp_valid_i = 1'b1;
      mem_rdata_i = pend_data;
      rsp_pend = 1'b0;
    end else if (mem_req_o && mem_mode != 2) begin
      if (mreq_q.size() == 0) begin
        chk("unexpected_mem_req", 32'(mem_req_o), 32'd0);
      end else begin
        m_r = mreq_q.pop_front();
        chk("mem_we", 32'(mem_we_o), 32'(m_r.we));
        chk("mem_addr", 32'(mem_addr_o), 32'(m_r.addr));
        chk("mem_wdata", mem_wdata_o, m_r.wdata);
      end
      mem_gnt_i = 1'b1;
      if (mem_mode == 1) begin
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = mem_data(mem_addr_o);
      end else if (mem_mode == 0) begin
        rsp_pend = 1'b1;
        pend_data = mem_data(mem_addr_o);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 50) begin
      neg();
      n++;
    end
    repeat (2) neg();
    chk(name, 32'(exp_q.size()) + 32'(busy_o), 32'd0);
  endtask

  initial begin
    int exp_ord[4] = '{0, 1, 0, 1};
    int n;
    int pl_cnt;
    int dbg_cnt;
    int low_cnt;
    logic seen_we;
    logic [DW-1:0] seen_wd;

    #1 reset_i = 1'b1;
    repeat (2) neg();
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_dbg_rsp", 32'(dbg_rsp_valid_o), 32'd0);
    chk("rst_pl_rsp", 32'(pl_rsp_valid_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_dbg_rdata", dbg_rdata_o, 32'd0);
    cyc();
    reset_i = 1'b0;

    // Round robin with both requesting continuously
    mem_mode = 0;
    halt_active_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 16'h0030;
    pl_req_i = 1'b1; pl_we_i = 1'b0; pl_addr_i = 16'h0020;
    n = 0;
    while (gnt_log.size() < 4 && n < 60) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    dbg_req_i = 1'b0;
    pl_req_i = 1'b0;
    drain("rr_drain");
    chk("rr_count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));
    end

    // Halted debug read, cycle-exact latency
    cyc();
    halt_active_i = 1'b1;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 16'h0010;
    neg();
    chk("t1_gnt_c0", 32'(dbg_gnt_o), 32'd1);
    cyc();
    dbg_req_i = 1'b0;
    neg();
    chk("t1_memreq_c1", 32'(mem_req_o), 32'd1);
    chk("t1_addr_c1", 32'(mem_addr_o), 32'h0010);
    neg();
    chk("t1_norsp_c2", 32'(dbg_rsp_valid_o), 32'd0);
    neg();
    chk("t1_rsp_c3", 32'(dbg_rsp_valid_o), 32'd1);
    chk("t1_rdata_c3", dbg_rdata_o, 32'hDEADBEEF);
    neg();
    chk("t1_pulse_c4", 32'(dbg_rsp_valid_o), 32'd0);
    chk("t1_hold_rdata", dbg_rdata_o, 32'hDEADBEEF);

    // Pipeline held off while halted; debug write passes
    cyc();
    pl_req_i = 1'b1; pl_we_i = 1'b1; pl_addr_i = 16'h0040; pl_wdata_i = 32'h5555AAAA;
    pl_cnt = 0; dbg_cnt = 0; seen_we = 1'b0; seen_wd = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 16'h0004; dbg_wdata_i = 32'h0000_1234;
      end
      neg();
      if (pl_gnt_o) pl_cnt++;
      if (dbg_gnt_o) dbg_cnt++;
      if (mem_req_o) begin
        seen_we = mem_we_o;
        seen_wd = mem_wdata_o;
      end
      cyc();
      if (dbg_cnt != 0) dbg_req_i = 1'b0;
    end
    chk("t3_pl_held", 32'(pl_cnt), 32'd0);
    chk("t3_dbg_gnts", 32'(dbg_cnt), 32'd1);
    chk("t3_mem_we", 32'(seen_we), 32'd1);
    chk("t3_mem_wdata", seen_wd, 32'h0000_1234);
    halt_active_i = 1'b0;
    neg();
    chk("t3_pl_gnt_unhalt", 32'(pl_gnt_o), 32'd1);
    cyc();
    pl_req_i = 1'b0;
    drain("t3_drain");

    // Timeout on a pipeline read that is never granted
    cyc();
    mem_mode = 2;
    pl_req_i = 1'b1; pl_we_i = 1'b0; pl_addr_i = 16'h0050;
    neg();
    chk("to_gnt_c0", 32'(pl_gnt_o), 32'd1);
    cyc();
    pl_req_i = 1'b0;
    low_cnt = 0;
    for (int c = 1; c <= TO; c++) begin
      neg();
      if (!mem_req_o || pl_rsp_valid_o) low_cnt++;
    end
    chk("to_req_held", 32'(low_cnt), 32'd0);
    neg();
    chk("to_rsp_c9", 32'(pl_rsp_valid_o), 32'd1);
    chk("to_err_c9", 32'(pl_err_o), 32'd1);
    chk("to_rdata_c9", pl_rdata_o, 32'd0);
    chk("to_req_drop", 32'(mem_req_o), 32'd0);
    cyc();
    stale = 1'b1;
    cyc();
    stale = 1'b0;
    neg();
    chk("stale_busy", 32'(busy_o), 32'd0);
    chk("stale_no_rsp", 32'(pl_rsp_valid_o), 32'd0);
    neg();
    chk("stale_no_rsp2", 32'(pl_rsp_valid_o), 32'd0);
    mreq_q.delete();
    mem_mode = 0;

    // Reset while waiting in RSP
    cyc();
    halt_active_i = 1'b1;
    mem_mode = 3;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 16'h0060;
    neg();
    chk("rst_t_gnt", 32'(dbg_gnt_o), 32'd1);
    cyc();
    dbg_req_i = 1'b0;
    neg();
    neg();
    chk("rst_t_busy_pre", 32'(busy_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy_o), 32'd0);
    chk("rst_async_req", 32'(mem_req_o), 32'd0);
    chk("rst_async_dbg_rsp", 32'(dbg_rsp_valid_o), 32'd0);
    chk("rst_async_pl_rsp", 32'(pl_rsp_valid_o), 32'd0);
    chk("rst_async_pl_err", 32'(pl_err_o), 32'd0);
    exp_q.delete();
    mreq_q.delete();
    cyc();
    reset_i = 1'b0;

    // First tie after reset, then grant+response in the first REQ cycle
    halt_active_i = 1'b0;
    mem_mode = 1;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 16'h0010;
    pl_req_i = 1'b1; pl_we_i = 1'b0; pl_addr_i = 16'h0070;
    neg();
    chk("tie_dbg_wins", 32'(dbg_gnt_o), 32'd1);
    chk("tie_pl_waits", 32'(pl_gnt_o), 32'd0);
    cyc();
    dbg_req_i = 1'b0;
    neg();
    chk("fast_req_c1", 32'(mem_req_o), 32'd1);
    neg();
    chk("fast_rsp_c2", 32'(dbg_rsp_valid_o), 32'd1);
    chk("fast_rdata_c2", dbg_rdata_o, 32'hDEADBEEF);
    chk("fast_pl_gnt_c2", 32'(pl_gnt_o), 32'd1);
    cyc();
    pl_req_i = 1'b0;
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbg_mem_arbiter.md
Name: dbg_mem_arbiter

Overview:
Shares the single hart memory/register access port between the pipeline load/store path and the debug module's abstract-access path. Serialises requests with one outstanding transaction. Arbitration is round-robin while the core runs and debug-only while it is halted. Sits between the HART block and the memory/register-file port; a per-access timeout returns an error instead of hanging the debugger.

Parameters:
ADDR_W, 16, address width of all request paths
DATA_W, 32, data width of all request and response paths
TIMEOUT_CYC, 64, cycles allowed from mem_req_o rise to mem_rsp_valid_i; 0 disables timeout

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-high
halt_active_i  in  1  core halted (debug mode)
dbg_req_i  in  1  debug request; held until dbg_gnt_o
dbg_we_i  in  1  1=write, 0=read
dbg_addr_i  in  ADDR_W  debug address
dbg_wdata_i  in  DATA_W  debug write data
dbg_gnt_o  out  1  one-cycle accept pulse
dbg_rsp_valid_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  DATA_W  read data, valid with dbg_rsp_valid_o
dbg_err_o  out  1  timeout error, valid with dbg_rsp_valid_o
pl_req_i / pl_we_i / pl_addr_i / pl_wdata_i  in  1/1/ADDR_W/DATA_W  pipeline request (same rules as dbg_*)
pl_gnt_o / pl_rsp_valid_o / pl_rdata_o / pl_err_o  out  1/1/DATA_W/1  pipeline response (same rules as dbg_*)
mem_req_o  out  1  shared-port request; held until mem_gnt_i
mem_we_o  out  1  latched write enable
mem_addr_o  out  ADDR_W  latched address
mem_wdata_o  out  DATA_W  latched write data
mem_gnt_i  in  1  port accepted request
mem_rsp_valid_i  in  1  port completed access (reads and writes)
mem_rdata_i  in  DATA_W  read data, valid with mem_rsp_valid_i
busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, last_owner=PL (debug wins the first tie), timeout counter 0. Reset asserted mid-transaction drops mem_req_o immediately. No response is issued for the aborted access.
- FSM states: IDLE, REQ, RSP.
- IDLE: eligible set = {dbg_req_i} if halt_active_i, else {dbg_req_i, pl_req_i}.
  - One eligible requester: it wins.
  - Both eligible: the one not equal to last_owner wins.
  - Winner's gnt_o is driven combinationally in the same cycle. Owner, we, addr and wdata are latched, last_owner is updated, and the FSM goes to REQ.
  - No eligible requester: stay in IDLE.
- REQ: mem_req_o=1 with latched fields. When mem_gnt_i=1, go to RSP.
- RSP: mem_req_o=0. When mem_rsp_valid_i=1, go to IDLE next cycle. In that next cycle, pulse the owner's rsp_valid_o for one cycle with rdata = registered mem_rdata_i (0 for writes) and err=0.
- mem_gnt_i and mem_rsp_valid_i may both be high in the same REQ cycle. Treat this as REQ→IDLE with the response issued next cycle.
- Minimum latency: gnt at cycle 0, mem_req_o at cycle 1, rsp_valid_o at cycle 2.
- A new grant can occur in the same cycle as the previous rsp_valid_o pulse, because the FSM is already in IDLE.
- Timeout: the counter increments every cycle in REQ/RSP. If TIMEOUT_CYC≠0 and the count reaches TIMEOUT_CYC without completion:
  - go to IDLE and deassert mem_req_o;
  - pulse the owner's rsp_valid_o with err=1 and rdata=0.
  - The counter clears on entering REQ.
- mem_rsp_valid_i or mem_gnt_i seen in IDLE (stale, after a timeout) is ignored.
- halt_active_i rising while a pipeline transaction is in flight: the transaction completes normally. Later pipeline requests are held (no gnt) until halt_active_i falls.
- Requesters must hold req and fields stable until gnt. Dropping req before gnt is legal and has no effect.
- rdata and err outputs hold their last value between pulses; only rsp_valid_o is qualifying.
- busy_o = (state != IDLE).

Decomposition:
- Package dbg_mem_arb_pkg contains:
  - state enum {IDLE, REQ, RSP};
  - owner enum {OWN_DBG, OWN_PL};
  - default ADDR_W/DATA_W localparams.
- One sub-module, rr_arb2: combinational two-input round-robin selector with mask input (halt masks the pipeline) and last_owner input; outputs winner and valid.

Test Plan:
- Debug read only, halt_active_i=1, addr 0x0010, mem returns 0xDEADBEEF one cycle after gnt → dbg_gnt_o cycle 0, mem_req_o cycle 1, dbg_rsp_valid_o cycle 3 with rdata 0xDEADBEEF, err=0.
- Both request continuously, halt_active_i=0, 4 accesses → grant order DBG, PL, DBG, PL. Each waits for the previous response; mem_req_o never high during RSP.
- halt_active_i=1, pl_req_i held 20 cycles plus one debug write 0x1234 to 0x0004 → only the debug access is issued (mem_we_o=1, mem_wdata_o=0x1234); pl_gnt_o stays 0 until halt drops, then granted the same cycle.
- TIMEOUT_CYC=8, mem_gnt_i never asserts on a pipeline read → pl_rsp_valid_o pulses with err=1, rdata=0, 8 cycles after mem_req_o rose; a late mem_rsp_valid_i is ignored.
- reset_i pulsed while in RSP → mem_req_o, busy_o and all rsp_valid_o are 0 asynchronously; after release a debug read completes normally and wins the first tie.
- mem_gnt_i and mem_rsp_valid_i both high in the first REQ cycle → rsp_valid_o on cycle 2, and a pending pipeline request is granted in that same cycle.
